if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling fetch queue. It issues sequential word fetches to instruction memory with up to `MAX_OUTST` requests in flight and buffers in-order responses in a `FQ_DEPTH`-entry queue. It presents one instruction and its PC per cycle to decode, and supports stall and flush/redirect. Responses belonging to squashed requests are discarded. It replaces the single-entry fetch stage at the front of the core pipeline.

## Interface
Parameters:
- `XLEN`, 32, PC/address width.
- `FQ_DEPTH`, 4, fetch-queue entries, power of two, ≥2.
- `MAX_OUTST`, 2, maximum outstanding memory requests, 1..FQ_DEPTH.
- `RESET_PC`, 32'h0000_0000, first fetch address.

Ports:
- `clk` in 1: sole clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_stall` in 1: decode cannot accept; hold head.
- `i_flush` in 1: squash all buffered/in-flight fetches and redirect.
- `i_redirect_pc` in XLEN: new fetch PC, sampled when `i_flush`=1.
- `o_imem_req` out 1: fetch request valid.
- `o_imem_addr` out XLEN: word address of request (bits[1:0]=0).
- `i_imem_gnt` in 1: request accepted this cycle.
- `i_imem_rvalid` in 1: response valid; responses strictly in request order, ≥1 cycle after grant.
- `i_imem_rdata` in 32: response instruction word.
- `o_if_valid` out 1: queue head valid.
- `o_if_pc` out XLEN: PC of head instruction.
- `o_if_instr` out 32: head instruction.

## Operation
- State: `fetch_pc` (next address to request), `resp_pc` (PC of next accepted response), `outst` counter (0..MAX_OUTST), `discard` counter (0..MAX_OUTST), and a queue of {pc, instr} with `count` (0..FQ_DEPTH).
- Request rule: `o_imem_req` = !rst & !i_flush & (outst < MAX_OUTST) & (outst + count < FQ_DEPTH). This credit check guarantees no queue overflow. It uses the current-cycle `count` with no pop lookahead.
- Once `o_imem_req`=1 without grant, `o_imem_req` and `o_imem_addr` stay stable until `i_imem_gnt`. The only exception is `i_flush`, which may retract the request.
- Handshake (`req & gnt`): `fetch_pc += 4` (mod 2^XLEN wrap), `outst++`.
- Response with `discard`>0: drop the word, `discard--`, `outst--`.
- Response with `discard`=0: push {resp_pc, rdata}, `resp_pc += 4`, `outst--`.
- Pop: when `o_if_valid & !i_stall`. Simultaneous push and pop at any count is legal, and `count` is unchanged.
- Flush (highest priority):
  - `fetch_pc` and `resp_pc` ← `i_redirect_pc`.
  - Queue cleared and no pop.
  - A response arriving in the flush cycle is dropped.
  - `discard` ← `outst` − `i_imem_rvalid`, and `outst` is updated the same way.
  - No handshake can occur because req is forced to 0.
- Back-to-back flushes accumulate correctly because `outst` covers every in-flight request.
- Flush while `i_stall`=1: flush wins; the queue is emptied.

## Timing
- Reset values: `o_imem_req`=0, `o_imem_addr`=RESET_PC, `o_if_valid`=0, `o_if_pc`=0, `o_if_instr`=0. All counters are 0, `fetch_pc` and `resp_pc` are RESET_PC.
- A reset asserted mid-operation discards all state. Responses to pre-reset requests are the memory's responsibility and must not arrive after reset.
- The first request is asserted in the first cycle with `rst`=0.
- Response → output latency: 1 cycle. A word with rvalid at cycle N appears on `o_if_*` at N+1 if the queue was empty. There is no bypass.
- Outputs are registered/queue-head driven and are held stable while `i_stall`=1.
- Flush → new request: the request to `i_redirect_pc` is issued in cycle F+1. `o_if_valid`=0 from F+1 until the first post-flush response is queued.
- Peak throughput is 1 instr/cycle when grant is immediate, latency ≤ MAX_OUTST cycles, and no stall.

## Test plan
- Reset release, gnt always 1, 1-cycle response latency, rdata=addr^32'hA5A5_0000 → requests 0,4,8,…; `o_if_pc`/`o_if_instr` pairs match in order, sustained 1/cycle after fill.
- Hold `i_stall`=1 for 10 cycles → queue fills to FQ_DEPTH, `o_imem_req` drops when outst+count=FQ_DEPTH, head stays PC 0x0. Releasing the stall resumes with no lost or duplicated PCs.
- `i_imem_gnt`=0 for 5 cycles with req high → `o_imem_addr` stable at same value. No `outst` increment.
- 3-cycle response latency, two requests outstanding (0x10, 0x14), `i_flush` with redirect 0x200 → both stale responses dropped. Next output PC=0x200 with its matching instr.
- Flush in the same cycle as a stale response plus stall, followed by a second flush 1 cycle later to 0x300 → only 0x300 stream appears, `discard` returns to 0.
- Fetch near 0xFFFF_FFF8 → addresses wrap to 0x0, PCs continue correctly.

Source files
------------

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Purpose:
//   Instruction-fetch stage with a decoupling fetch queue. It issues
//   sequential word fetches to instruction memory with up to MAX_OUTST
//   requests in flight. In-order responses are buffered in an FQ_DEPTH-entry
//   queue, and one {pc, instr} per cycle is presented to decode. Stall holds
//   the queue head. Flush squashes everything buffered or in flight and
//   redirects fetch to a new PC. Responses to squashed requests are counted
//   off and dropped as they return.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   i_stall         decode cannot accept, hold the head
//   i_flush         squash and redirect
//   i_redirect_pc   new fetch PC, sampled while i_flush=1
//   o_imem_req      fetch request valid
//   o_imem_addr     word address of the request
//   i_imem_gnt      request accepted this cycle
//   i_imem_rvalid   response valid (in request order)
//   i_imem_rdata    response instruction word
//   o_if_valid      queue head valid
//   o_if_pc         PC of the head instruction
//   o_if_instr      head instruction word
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int               XLEN      = 32,
  parameter int               FQ_DEPTH  = 4,
  parameter int               MAX_OUTST = 2,
  parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_instr
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  // Counters share one width; MAX_OUTST never exceeds FQ_DEPTH.
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  localparam logic [CNT_W-1:0] MAX_OUTST_C = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W:0]   DEPTH_C     = (CNT_W + 1)'(FQ_DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP     = XLEN'(4);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_outst;
  logic [CNT_W-1:0] r_discard;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [XLEN-1:0]  r_q_pc    [FQ_DEPTH];
  logic [31:0]      r_q_instr [FQ_DEPTH];

  logic [CNT_W:0]   w_credit;
  logic             w_req;
  logic             w_hs;
  logic             w_drop;
  logic             w_push;
  logic             w_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_rvalid_ext;

  // A new request is only issued if every in-flight request is guaranteed a
  // free queue slot when it returns. outst + count cannot grow while a
  // request waits for grant, so a pending request is never withdrawn except
  // by flush.
  assign w_credit     = {1'b0, r_outst} + {1'b0, r_count};
  assign w_req        = !rst && !i_flush && (r_outst < MAX_OUTST_C) && (w_credit < DEPTH_C);
  assign w_hs         = w_req && i_imem_gnt;
  assign w_drop       = i_imem_rvalid && (r_discard != '0);
  assign w_push       = i_imem_rvalid && (r_discard == '0) && !i_flush;
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && !i_stall && !i_flush;
  assign w_rvalid_ext = CNT_W'(i_imem_rvalid);

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc;
  assign o_if_valid  = w_valid;
  // Head fields read as zero while the queue is empty, so reset needs no
  // clearing of the storage array.
  assign o_if_pc     = w_valid ? r_q_pc[r_rd_ptr]    : '0;
  assign o_if_instr  = w_valid ? r_q_instr[r_rd_ptr] : '0;

  // Control state: PCs, in-flight/discard accounting and queue pointers.
  // Flush converts every request still in flight into a pending discard;
  // a response landing in the flush cycle itself is dropped immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (i_flush) begin
      r_fetch_pc <= i_redirect_pc;
      r_resp_pc  <= i_redirect_pc;
      r_outst    <= r_outst - w_rvalid_ext;
      r_discard  <= r_outst - w_rvalid_ext;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_hs) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      r_outst <= r_outst + CNT_W'(w_hs) - w_rvalid_ext;
      if (w_drop) begin
        r_discard <= r_discard - 1'b1;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + PC_STEP;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Queue storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
      r_q_instr[r_wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue. A small memory model answers granted
// requests after a programmable latency with rdata = addr ^ 32'hA5A5_0000.
// Every handshake pushes the expected {pc, instr} into a scoreboard, flush
// clears it, and every presented head is compared against the scoreboard.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } expEntry_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        ifValid;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;

  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  logic [31:0] modelPc;
  expEntry_t   scoreboard[$];
  memReq_t     pending[$];

  if_fetch_queue #(
    .XLEN(32), .FQ_DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clock),
    .rst(reset),
    .i_stall(stall),
    .i_flush(flush),
    .i_redirect_pc(redirectPc),
    .o_imem_req(imemReq),
    .o_imem_addr(imemAddr),
    .i_imem_gnt(imemGnt),
    .i_imem_rvalid(imemRvalid),
    .i_imem_rdata(imemRdata),
    .o_if_valid(ifValid),
    .o_if_pc(ifPc),
    .o_if_instr(ifInstr)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: counts it and reports a failure through an assertion
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, track handshakes and
  // flushes in the model, then drive the memory response for the next cycle
  task automatic applyStimulus();
    memReq_t   m;
    expEntry_t e;
    @(negedge clock);
    if (ifValid) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_valid", {31'b0, ifValid}, 32'd0);
      end else begin
        checkOutput("head_pc", ifPc, scoreboard[0].pc);
        checkOutput("head_instr", ifInstr, scoreboard[0].instr);
        if (!stall && !flush) void'(scoreboard.pop_front());
      end
    end
    if (flush) checkOutput("req_in_flush", {31'b0, imemReq}, 32'd0);
    if (imemReq) begin
      checkOutput("req_addr", imemAddr, modelPc);
      if (imemGnt) begin
        m.addr = modelPc;
        m.due  = cyc + lat;
        pending.push_back(m);
        e.pc    = modelPc;
        e.instr = modelPc ^ 32'hA5A5_0000;
        scoreboard.push_back(e);
        modelPc = modelPc + 32'd4;
      end
    end
    if (flush) begin
      scoreboard.delete();
      modelPc = redirectPc;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      m = pending.pop_front();
      imemRvalid = 1'b1;
      imemRdata  = m.addr ^ 32'hA5A5_0000;
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = 32'h0;
    end
  endtask

  // Run until the head becomes valid (bounded) and check its PC/instr
  task automatic waitHead(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    while (!ifValid && n < 30) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_valid"}, {31'b0, ifValid}, 32'd1);
    checkOutput({tag, "_pc"}, ifPc, pc);
    checkOutput({tag, "_instr"}, ifInstr, pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    int   n;
    logic found;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    lat        = 1;
    modelPc    = 32'h0;
    reset      = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    redirectPc = 32'h0;
    imemGnt    = 1'b1;
    imemRvalid = 1'b0;
    imemRdata  = 32'h0;

    // Reset state
    repeat (3) applyStimulus();
    checkOutput("rst_req", {31'b0, imemReq}, 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("rst_pc", ifPc, 32'h0);
    checkOutput("rst_instr", ifInstr, 32'h0);

    // Release: the first request appears in the first non-reset cycle
    reset = 1'b0;
    cyc   = 0;
    #1;
    checkOutput("first_req", {31'b0, imemReq}, 32'd1);
    checkOutput("first_addr", imemAddr, 32'h0);
    repeat (2) applyStimulus();
    for (int i = 0; i < 8; i++) begin
      checkOutput("sustained_valid", {31'b0, ifValid}, 32'd1);
      applyStimulus();
    end

    // Stall: queue fills, request drops once outst+count reaches depth
    stall = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("stall_req_off", {31'b0, imemReq}, 32'd0);
    checkOutput("stall_valid", {31'b0, ifValid}, 32'd1);
    stall = 1'b0;

    // Grant withheld: address stable, queue drains, nothing new in flight
    imemGnt = 1'b0;
    repeat (5) applyStimulus();
    checkOutput("nognt_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("nognt_req", {31'b0, imemReq}, 32'd1);
    checkOutput("nognt_addr", imemAddr, modelPc);

    // Two requests in flight at 3-cycle latency, then flush to 0x200
    imemGnt    = 1'b1;
    lat        = 3;
    flush      = 1'b1;
    redirectPc = 32'h10;
    applyStimulus();
    flush = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("two_outst_req", {31'b0, imemReq}, 32'd0);
    flush      = 1'b1;
    redirectPc = 32'h200;
    applyStimulus();
    flush = 1'b0;
    waitHead("redirect200", 32'h200);

    // Flush coinciding with a stale response under stall, then a second flush
    n = 0;
    while (imemRvalid !== 1'b1 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("stale_rvalid_seen", {31'b0, imemRvalid}, 32'd1);
    stall      = 1'b1;
    flush      = 1'b1;
    redirectPc = 32'h260;
    applyStimulus();
    redirectPc = 32'h300;
    applyStimulus();
    flush = 1'b0;
    stall = 1'b0;
    checkOutput("post_flush_valid", {31'b0, ifValid}, 32'd0);
    waitHead("redirect300", 32'h300);
    repeat (6) applyStimulus();

    // Address wrap from the top of the address space
    lat        = 1;
    flush      = 1'b1;
    redirectPc = 32'hFFFF_FFF8;
    applyStimulus();
    flush = 1'b0;
    waitHead("wrap_start", 32'hFFFF_FFF8);
    found = 1'b0;
    n = 0;
    while (!found && n < 12) begin
      applyStimulus();
      if (ifValid && ifPc == 32'h0) found = 1'b1;
      n++;
    end
    checkOutput("wrap_reached_zero", {31'b0, found}, 32'd1);
    checkOutput("wrap_instr", ifInstr, 32'hA5A5_0000);
    repeat (4) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
